// File: rtl/lcd_pixel_source.sv
// Test-pattern pixel source for the ST7789V3 memory-write phase.
// Emits RGB565 frames as a high-byte-first byte stream on valid/ready with frame flags.
module lcd_pixel_source #(
    parameter int unsigned H_RES      = 240,
    parameter int unsigned V_RES      = 280,
    parameter int unsigned CHECK_LOG2 = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [1:0]  mode_i,
    input  logic [15:0] solid_color_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [7:0]  data_o,
    output logic        first_o,
    output logic        last_o,
    output logic        busy_o
);

    localparam int unsigned XW = 8;
    localparam int unsigned YW = 9;
    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_START  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [15:0]   color_q, color_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          phase_q, phase_d;
    logic          valid_q, valid_d;
    logic [7:0]    data_q, data_d;
    logic          first_q, first_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;

    logic          frame_end;
    logic [2:0]    bar_idx;
    logic [15:0]   bar_color;
    logic [4:0]    grad_b;
    logic [15:0]   pix;

    // First x of bar k: smallest x with (x*8)/H_RES >= k, i.e. ceil(k*H_RES/8).
    function automatic logic [XW-1:0] bar_edge(input int unsigned k);
        return XW'((k * H_RES + 7) / 8);
    endfunction

    assign frame_end = (x_q == X_LAST) && (y_q == Y_LAST) && phase_q;

    // Next-state and output-register logic.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        color_d = color_q;
        x_d     = x_q;
        y_d     = y_q;
        phase_d = phase_q;
        valid_d = valid_q;
        first_d = first_q;
        last_d  = last_q;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                if (en_i) begin
                    state_d = S_START;
                    mode_d  = mode_i;
                    color_d = solid_color_i;
                    x_d     = '0;
                    y_d     = '0;
                    phase_d = 1'b0;
                end
            end
            S_START: begin
                state_d = S_STREAM;
                valid_d = 1'b1;
                busy_d  = 1'b1;
                first_d = 1'b1;
                last_d  = 1'b0;
            end
            S_STREAM: begin
                if (ready_i) begin
                    if (frame_end) begin
                        x_d     = '0;
                        y_d     = '0;
                        phase_d = 1'b0;
                        last_d  = 1'b0;
                        if (en_i) begin
                            mode_d  = mode_i;
                            color_d = solid_color_i;
                            first_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            first_d = 1'b0;
                        end
                    end else begin
                        phase_d = ~phase_q;
                        first_d = 1'b0;
                        if (phase_q) begin
                            if (x_q == X_LAST) begin
                                x_d = '0;
                                y_d = y_q + 9'd1;
                            end else begin
                                x_d = x_q + 8'd1;
                            end
                        end
                        last_d = (x_d == X_LAST) && (y_d == Y_LAST) && phase_d;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pixel of the byte that will be presented next.
    always_comb begin
        bar_idx = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (x_d >= bar_edge(k)) begin
                bar_idx = bar_idx + 3'd1;
            end
        end

        case (bar_idx)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase

        grad_b = 5'((YW'(x_d) + y_d) >> 4);

        case (mode_d)
            2'd0:    pix = color_d;
            2'd1:    pix = bar_color;
            2'd2:    pix = (x_d[CHECK_LOG2] ^ y_d[CHECK_LOG2]) ? 16'hFFFF : 16'h0000;
            default: pix = {x_d[7:3], y_d[8:3], grad_b};
        endcase
    end

    assign data_d = valid_d ? (phase_d ? pix[7:0] : pix[15:8]) : 8'h00;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            color_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            phase_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            color_q <= color_d;
            x_q     <= x_d;
            y_q     <= y_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            first_q <= first_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign first_o = first_q;
    assign last_o  = last_q;
    assign busy_o  = busy_q;

endmodule

// File: doc/lcd_pixel_source.md
# lcd_pixel_source

Pixel-stream generator feeding the ST7789V3 LCD driver during its memory-write phase. Produces full frames of RGB565 pixels as a byte stream (high byte first) on a valid/ready interface. Each frame is one of four selectable test patterns. Frame-boundary flags let the driver issue RAMWR and window commands per frame. It is the first content source for the display path and sits directly upstream of the driver's byte FIFO.

## Interface

- `H_RES`, default 240: active pixels per line. Range 1..255.
- `V_RES`, default 280: active lines per frame. Range 1..511.
- `CHECK_LOG2`, default 3: checkerboard square size is 2^CHECK_LOG2 pixels.

- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset; asynchronous, active-low.
- `en`  in  1  frame request; level-sensitive.
- `mode`  in  2  pattern select: 0 solid, 1 colour bars, 2 checkerboard, 3 gradient.
- `solid_color`  in  16  RGB565 value used by mode 0.
- `ready`  in  1  downstream accepts the byte this cycle.
- `valid`  out  1  `data` holds a byte.
- `data`  out  8  pixel byte.
- `first`  out  1  `data` is byte 0 of a frame.
- `last`  out  1  `data` is the final byte of a frame.
- `busy`  out  1  high while a frame is in progress (state STREAM).

## Operation

- State IDLE:
  - Outputs idle.
  - If `en` is high, latch `mode` and `solid_color`, clear counters, and go to STREAM.
- State STREAM, counters:
  - `x` is 8 bits, 0..H_RES-1.
  - `y` is 9 bits, 0..V_RES-1.
  - `phase` is 1 bit: 0 = high byte `pix[15:8]`, 1 = low byte `pix[7:0]`.
- Pixel order is raster: `x` fastest, then `y`.
- Counters advance only on a transfer (`valid && ready`):
  - `phase` toggles on every transfer.
  - `x` increments when `phase` is 1.
  - `x` wraps to 0 and `y` increments when `x == H_RES-1`.
- Frame end is the transfer where `x == H_RES-1`, `y == V_RES-1`, and `phase == 1`:
  - If `en` is high, re-latch `mode`/`solid_color`, zero the counters, and stay in STREAM (next frame, no bubble).
  - Otherwise go to IDLE.
- Frame length is H_RES×V_RES×2 bytes, which is 134400 at the defaults.
- Pixel function, using the latched mode:
  - Mode 0: `solid_color`.
  - Mode 1: eight vertical bars. Bar index is `(x*8)/H_RES`, integer division. Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Mode 2: `(x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? FFFF : 0000`.
  - Mode 3: R5 = `x[7:3]`, G6 = `y[8:3]`, B5 = `(x+y)[8:4]`. The sum `x+y` is 9 bits, and any carry out is discarded.
- Deasserting `en` mid-frame does not truncate. The current frame always completes.
- Changing `mode` or `solid_color` mid-frame has no effect until the next frame start.
- Reset asserted at any time immediately forces IDLE. All outputs go low and counters clear. No partial-frame recovery.

## Timing

- Reset value of every output:
  - `valid`, `first`, `last`, `busy` = 0.
  - `data` = 8'h00.
- All outputs are registered. There are no combinational paths from `ready`, `en`, or `mode` to any output.
- Start latency:
  - `en` is sampled high in IDLE at edge N.
  - `valid`, `first`, and `busy` are high after edge N+1, with `data` = high byte of pixel (0,0).
- Handshake:
  - Once `valid` rises, `valid`, `data`, `first`, and `last` hold unchanged until the cycle a transfer occurs. No valid withdrawal.
  - With `ready` held high, one byte transfers per cycle.
  - The next byte is presented on the edge that completes the current transfer.
- `first` is high only with byte 0 of a frame.
- `last` is high only with the final byte of a frame.
- With H_RES=V_RES=1 the frame is 2 bytes, and `first` and `last` are never high on the same byte.
- End of frame:
  - If `en` is low at the final transfer, `valid` and `busy` drop on that edge.
  - If `en` is high, the next frame's `first` byte is presented on that edge (zero idle cycles).

## Test plan

- Reset, mode 0, `solid_color`=16'hF800, `en` pulsed 1 cycle, `ready`=1:
  - `valid` rises 1 cycle after the pulse.
  - Exactly 134400 bytes alternating F8, 00.
  - `first` only on byte 0, `last` only on byte 134399.
  - `busy` and `valid` drop after the last byte.
- Mode 1, `ready`=1:
  - Line 0 bytes for x=0..29 are FF,FF and for x=30..59 are FF,E0.
  - x=210..239 give 00,00.
  - Identical bars on line 279.
- Mode 2, CHECK_LOG2=3:
  - Pixel (0,0) = 0000, (8,0) = FFFF, (8,8) = 0000, (239,279) = FFFF.
- Mode 3, pseudo-random `ready`, about 30% duty:
  - `data`, `first`, and `last` stay stable while `valid && !ready`.
  - Pixel (100,200) = {5'd12, 6'd25, 5'd18} = 16'h6332.
  - Total byte count is still 134400.
- `en` held high across the frame end, with `mode` changed from 0 to 2 mid-frame:
  - The second frame's `first` byte follows `last` with no gap.
  - The first frame stays solid to its end.
  - The second frame is checkerboard.
- `rst` asserted at byte 5000:
  - All outputs are 0 asynchronously.
  - After release with `en`=1, the stream restarts at pixel (0,0) with `first`=1.
